// File: rtl/logic_operand_fetch.sv
// Issue stage for the bitwise logic unit: register file, pending-destination scoreboard,
// write-back bypass and a one-entry output register with valid/ready handshake.
module logic_operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [REG_AW-1:0]     in_rs0,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  in_imm_en,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_in_0,
  output logic [DATA_WIDTH-1:0] out_in_1,
  output logic [1:0]            out_op_selector,
  output logic [REG_AW-1:0]     out_rd,
  input  logic                  wb_valid,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_in_0;
  logic [DATA_WIDTH-1:0] r_out_in_1;
  logic [1:0]            r_out_op;
  logic [REG_AW-1:0]     r_out_rd;

  logic [NUM_REGS-1:0]   w_wb_mask;
  logic [NUM_REGS-1:0]   w_eff_pend;
  logic                  w_rs1_used;
  logic                  w_hazard;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_op0;
  logic [DATA_WIDTH-1:0] w_op1;

  // r0 is hard-wired zero; a same-cycle write-back to a non-zero source is forwarded.
  function automatic logic [DATA_WIDTH-1:0] read_operand(input logic [REG_AW-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    if (idx == '0)
      v = '0;
    else if (wb_valid && (wb_rd == idx))
      v = wb_data;
    else
      v = r_regs[idx];
    return v;
  endfunction

  assign w_wb_mask  = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
  assign w_eff_pend = r_pend & ~w_wb_mask;
  assign w_rs1_used = !in_imm_en && (in_op != 2'b11);
  assign w_hazard   = in_valid && (w_eff_pend[in_rs0] ||
                                   (w_rs1_used && w_eff_pend[in_rs1]) ||
                                   w_eff_pend[in_rd]);
  assign in_ready   = !w_hazard && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_op0 = read_operand(in_rs0);
    w_op1 = '0;
    if (in_imm_en)
      w_op1 = in_imm;
    else if (in_op != 2'b11)
      w_op1 = read_operand(in_rs1);
  end

  // Register file and scoreboard; the issue-side pending set is applied last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) begin
        r_regs[wb_rd] <= wb_data;
        r_pend[wb_rd] <= 1'b0;
      end
      if (w_accept && (in_rd != '0))
        r_pend[in_rd] <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_in_0  <= '0;
      r_out_in_1  <= '0;
      r_out_op    <= '0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_in_0  <= w_op0;
      r_out_in_1  <= w_op1;
      r_out_op    <= in_op;
      r_out_rd    <= in_rd;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_in_0        = r_out_in_0;
  assign out_in_1        = r_out_in_1;
  assign out_op_selector = r_out_op;
  assign out_rd          = r_out_rd;

endmodule

// File: doc/logic_operand_fetch.md
Name: logic_operand_fetch

Overview:
- Upstream issue stage for the bitwise logic unit.
- Accepts decoded logic instructions, reads operands from a local register file, and tracks pending destinations with a scoreboard.
- Drives registered in_0/in_1/op_selector to the logic unit and accepts write-back of results into the register file.
- One-entry output register with valid/ready handshake; 1-cycle issue latency.

Parameters:
- DATA_WIDTH, `INSTRUCTION_WIDTH (32): operand/result width.
- NUM_REGS, 16: register file depth (power of two, at least 2).
- REG_AW, $clog2(NUM_REGS): register index width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction valid.
- in_ready  output  1  stage accepts instruction this cycle.
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NOT(in_0).
- in_rs0  input  REG_AW  source 0 index.
- in_rs1  input  REG_AW  source 1 index; ignored when in_imm_en=1 or in_op=11.
- in_rd  input  REG_AW  destination index.
- in_imm_en  input  1  use in_imm as operand 1.
- in_imm  input  DATA_WIDTH  immediate operand.
- out_valid  output  1  operands valid to logic unit.
- out_ready  input  1  downstream accepts.
- out_in_0  output  DATA_WIDTH  operand 0.
- out_in_1  output  DATA_WIDTH  operand 1.
- out_op_selector  output  2  registered in_op.
- out_rd  output  REG_AW  destination, carried to write-back.
- wb_valid  input  1  result write-back strobe.
- wb_rd  input  REG_AW  write-back destination.
- wb_data  input  DATA_WIDTH  write-back value.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): all registers, out_* outputs and the pending scoreboard clear to 0. out_valid=0 in the cycle after reset. in_ready is combinational and follows its equation.
- Register 0 always reads 0. Writes to r0 are discarded, and r0 is never marked pending.
- Write-back: on wb_valid, regs[wb_rd] <= wb_data and pending[wb_rd] clears, at the same edge.
- Effective pending: eff_pend = pending with bit wb_rd cleared when wb_valid=1.
- Hazard: in_valid and any of the following:
  - eff_pend[in_rs0]=1;
  - eff_pend[in_rs1]=1 (only when rs1 is used);
  - eff_pend[in_rd]=1 (WAW).
- Handshake: in_ready = !hazard && (!out_valid || out_ready). An instruction is accepted when in_valid && in_ready.
- Operand read bypass: if wb_valid and wb_rd==source index (non-zero), the operand takes wb_data, otherwise regs[idx]. out_in_1 takes in_imm when in_imm_en=1, and 0 when in_op=11 and in_imm_en=0.
- On accept, at the next edge:
  - out_valid<=1;
  - out_in_0, out_in_1, out_op_selector and out_rd load;
  - pending[in_rd]<=1 if in_rd!=0.
- Same-cycle write-back clear and issue set on the same index: the set wins.
- No accept and out_ready=1: out_valid<=0. When out_valid=1 and out_ready=0, all out_* hold stable.
- Throughput: 1 instruction/cycle with no hazards and out_ready=1.
- Stalled input (hazard): in_ready=0, in_valid may stay high, and the stage keeps no state for the stalled instruction.
- Reset mid-operation: the pending output is dropped and all scoreboard bits clear. A wb_valid in the reset cycle is ignored.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, reads of r1..r15 return 0.
- wb r1=0xF0F0_F0F0, r2=0x0FF0_0FF0; then issue op=10 rs0=1 rs1=2 rd=3 -> next cycle out_valid=1, out_in_0=0xF0F0_F0F0, out_in_1=0x0FF0_0FF0, out_op_selector=10, out_rd=3.
- RAW hazard:
  - Issue rd=3, then op=00 rs0=3 -> in_ready=0 until wb_valid rd=3 data=0xFF00_FF00.
  - In that write-back cycle the instruction is accepted with out_in_0=0xFF00_FF00 (bypass).
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable; out_ready=1 -> next instruction issues the next cycle.
- Immediate and NOT:
  - op=01 imm_en=1 imm=0x0000_00FF rs0=0 -> out_in_0=0, out_in_1=0xFF.
  - op=11 rs0=1 imm_en=0 -> out_in_1=0.
  - rd=0 never blocks a later instruction.
- rst asserted while out_valid=1 and r5 pending -> next cycle out_valid=0; an instruction reading r5 is accepted immediately with operand 0.
